// File: rtl/vend_dispense_ctrl.sv
// Vending dispense controller: price check, timed motor drive, drop-sensor wait
// with jam timeout, then greedy change ejection (quarter/dime/nickel in nickel units).
module vend_dispense_ctrl #(
    parameter int MOTOR_CYCLES = 8,
    parameter int TIMEOUT      = 64,
    parameter int COIN_GAP     = 4,
    parameter int PRICE0       = 2,
    parameter int PRICE1       = 3,
    parameter int PRICE2       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vend_req,
    input  logic [1:0] sel,
    input  logic [4:0] credit,
    input  logic       item_sensed,
    output logic       busy,
    output logic       motor_on,
    output logic       coin_out,
    output logic [1:0] coin_type,
    output logic       done,
    output logic [1:0] err_code
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_MOTOR = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_CHG   = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam int CNT_MAX0 = (MOTOR_CYCLES > TIMEOUT) ? MOTOR_CYCLES : TIMEOUT;
    localparam int CNT_MAX  = (CNT_MAX0 > COIN_GAP) ? CNT_MAX0 : COIN_GAP;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] MOT_LAST = CNT_W'(MOTOR_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(COIN_GAP - 1);

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_FUNDS = 2'b01;
    localparam logic [1:0] ERR_SEL   = 2'b10;
    localparam logic [1:0] ERR_JAM   = 2'b11;

    logic [2:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [4:0]       change, change_nx;
    logic [1:0]       err, err_nx;
    logic [1:0]       sel_q;
    logic [4:0]       credit_q;
    logic             sensed, sensed_nx;
    logic             coin_fire;
    logic [1:0]       coin_type_nx;
    logic [4:0]       price;

    always_comb begin
        case (sel_q)
            2'b00:   price = 5'(PRICE0);
            2'b01:   price = 5'(PRICE1);
            2'b10:   price = 5'(PRICE2);
            default: price = 5'd0;
        endcase
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        change_nx    = change;
        err_nx       = err;
        sensed_nx    = sensed;
        coin_fire    = 1'b0;
        coin_type_nx = 2'b00;
        case (state)
            S_IDLE: if (vend_req) state_nx = S_CHECK;
            S_CHECK: begin
                sensed_nx = 1'b0;
                cnt_nx    = '0;
                if (sel_q == 2'b11) begin
                    change_nx = credit_q;
                    err_nx    = ERR_SEL;
                    state_nx  = S_CHG;
                end else if (credit_q < price) begin
                    change_nx = credit_q;
                    err_nx    = ERR_FUNDS;
                    state_nx  = S_CHG;
                end else begin
                    change_nx = credit_q - price;
                    err_nx    = ERR_OK;
                    state_nx  = S_MOTOR;
                end
            end
            S_MOTOR: begin
                if (item_sensed) sensed_nx = 1'b1;
                if (cnt == MOT_LAST) begin
                    cnt_nx   = '0;
                    state_nx = S_WAIT;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_WAIT: begin
                if (sensed || item_sensed) begin
                    state_nx = S_CHG;
                end else if (cnt == TO_LAST) begin
                    // jam: nothing was dispensed, so refund the whole credit
                    change_nx = credit_q;
                    err_nx    = ERR_JAM;
                    state_nx  = S_CHG;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_CHG: begin
                if (change == 5'd0) begin
                    state_nx = S_DONE;
                end else begin
                    coin_fire = 1'b1;
                    cnt_nx    = '0;
                    state_nx  = S_GAP;
                    if (change >= 5'd5) begin
                        coin_type_nx = 2'b10;
                        change_nx    = change - 5'd5;
                    end else if (change >= 5'd2) begin
                        coin_type_nx = 2'b01;
                        change_nx    = change - 5'd2;
                    end else begin
                        coin_type_nx = 2'b00;
                        change_nx    = change - 5'd1;
                    end
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) state_nx = S_CHG;
                else                 cnt_nx   = cnt + 1'b1;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // outputs are registered from the next state so they line up with the state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            change    <= 5'd0;
            err       <= ERR_OK;
            sensed    <= 1'b0;
            sel_q     <= 2'b00;
            credit_q  <= 5'd0;
            busy      <= 1'b0;
            motor_on  <= 1'b0;
            coin_out  <= 1'b0;
            coin_type <= 2'b00;
            done      <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            change   <= change_nx;
            err      <= err_nx;
            sensed   <= sensed_nx;
            if (state == S_IDLE && vend_req) begin
                sel_q    <= sel;
                credit_q <= credit;
            end
            busy     <= (state_nx != S_IDLE);
            motor_on <= (state_nx == S_MOTOR);
            coin_out <= coin_fire;
            if (coin_fire) coin_type <= coin_type_nx;
            done     <= (state_nx == S_DONE);
            if (state_nx == S_DONE) err_code <= err_nx;
        end
    end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl: one task per scenario, outputs sampled on negedge.
module tb_vend_dispense_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vend_req = 1'b0;
    logic [1:0] sel = 2'b00;
    logic [4:0] credit = 5'd0;
    logic       item_sensed = 1'b0;
    logic       busy, motor_on, coin_out, done;
    logic [1:0] coin_type, err_code;

    int checks = 0;
    int failures = 0;

    int cyc, mot, last_mot, n, dn, dcyc, ws;
    int ccyc[16];
    logic [1:0] ctype[16];
    logic [1:0] derr;
    logic busy_first, busy_after;

    vend_dispense_ctrl dut (
        .clk(clk), .reset(reset), .vend_req(vend_req), .sel(sel), .credit(credit),
        .item_sensed(item_sensed), .busy(busy), .motor_on(motor_on), .coin_out(coin_out),
        .coin_type(coin_type), .done(done), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic clear_mon();
        cyc = 0; mot = 0; last_mot = 0; n = 0; dn = 0; dcyc = 0; ws = 0; derr = 2'b00;
        for (int i = 0; i < 16; i++) begin ccyc[i] = 0; ctype[i] = 2'b00; end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (motor_on) begin mot++; last_mot = cyc; end
        if (coin_out) begin
            if (n < 16) begin ccyc[n] = cyc; ctype[n] = coin_type; end
            n++;
        end
        if (done) begin dn++; derr = err_code; dcyc = cyc; end
        ws = (mot > 0 && !motor_on) ? cyc - last_mot : 0;
    endtask

    // sense_at: -1 never, 0 one pulse during MOTOR, k>0 pulse in WAIT_SENSE cycle k
    task automatic do_vend(input logic [1:0] s, input logic [4:0] c, input int sense_at, input bit poke);
        clear_mon();
        sel = s; credit = c; vend_req = 1'b1;
        tick();
        busy_first = busy;
        vend_req = 1'b0;
        if (poke) begin sel = 2'b11; credit = 5'd31; end
        for (int i = 0; i < 400 && dn == 0; i++) begin
            if (sense_at == 0) item_sensed = (mot == 2);
            else if (sense_at > 0) item_sensed = (ws == sense_at);
            else item_sensed = 1'b0;
            if (poke) vend_req = (i % 3 == 0);
            tick();
        end
        item_sensed = 1'b0;
        vend_req = 1'b0;
        if (dn == 0) begin
            failures++;
            $display("FAIL done_timeout got=no_done exp=done");
        end
        checks++;
        tick();
        busy_after = busy;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #3;
        checks++;
        if ({busy, motor_on, coin_out, done, coin_type, err_code} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=00", {busy, motor_on, coin_out, done, coin_type, err_code});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_pen_dime();
        do_vend(2'b10, 5'd7, 3, 1'b1);
        checks++; if (busy_first !== 1'b1) begin failures++; $display("FAIL pen_busy_rise got=%b exp=1", busy_first); end
        checks++; if (mot !== 8) begin failures++; $display("FAIL pen_motor_cycles got=%0d exp=8", mot); end
        checks++; if (n !== 1) begin failures++; $display("FAIL pen_coin_count got=%0d exp=1", n); end
        checks++; if (ctype[0] !== 2'b01) begin failures++; $display("FAIL pen_coin_type got=%b exp=01", ctype[0]); end
        checks++; if (ccyc[0] - last_mot !== 5) begin failures++; $display("FAIL pen_sense_latency got=%0d exp=5", ccyc[0] - last_mot); end
        checks++; if (derr !== 2'b00 || dn !== 1) begin failures++; $display("FAIL pen_done got=%b/%0d exp=00/1", derr, dn); end
        checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL pen_busy_fall got=%b exp=0", busy_after); end
    endtask

    task automatic test_insufficient();
        do_vend(2'b00, 5'd1, -1, 1'b0);
        checks++; if (mot !== 0) begin failures++; $display("FAIL funds_motor got=%0d exp=0", mot); end
        checks++; if (n !== 1 || ctype[0] !== 2'b00) begin failures++; $display("FAIL funds_coin got=%0d/%b exp=1/00", n, ctype[0]); end
        checks++; if (derr !== 2'b01) begin failures++; $display("FAIL funds_err got=%b exp=01", derr); end
    endtask

    task automatic test_invalid_sel();
        do_vend(2'b11, 5'd6, -1, 1'b0);
        checks++; if (n !== 2) begin failures++; $display("FAIL inval_coin_count got=%0d exp=2", n); end
        checks++; if (ctype[0] !== 2'b10 || ctype[1] !== 2'b00) begin failures++; $display("FAIL inval_coin_types got=%b,%b exp=10,00", ctype[0], ctype[1]); end
        checks++; if (ccyc[1] - ccyc[0] !== 5) begin failures++; $display("FAIL inval_coin_gap got=%0d exp=5", ccyc[1] - ccyc[0]); end
        checks++; if (dcyc - ccyc[1] !== 5) begin failures++; $display("FAIL inval_done_lat got=%0d exp=5", dcyc - ccyc[1]); end
        checks++; if (derr !== 2'b10 || mot !== 0) begin failures++; $display("FAIL inval_err got=%b/%0d exp=10/0", derr, mot); end
    endtask

    task automatic test_jam_timeout();
        // a stale sensor pulse while idle must not count as a drop
        item_sensed = 1'b1; tick(); item_sensed = 1'b0; tick();
        do_vend(2'b01, 5'd3, -1, 1'b0);
        checks++; if (mot !== 8) begin failures++; $display("FAIL jam_motor got=%0d exp=8", mot); end
        checks++; if (ccyc[0] - last_mot !== 66) begin failures++; $display("FAIL jam_wait got=%0d exp=66", ccyc[0] - last_mot); end
        checks++; if (n !== 2 || ctype[0] !== 2'b01 || ctype[1] !== 2'b00) begin failures++; $display("FAIL jam_refund got=%0d/%b,%b exp=2/01,00", n, ctype[0], ctype[1]); end
        checks++; if (derr !== 2'b11) begin failures++; $display("FAIL jam_err got=%b exp=11", derr); end
    endtask

    task automatic test_max_change();
        logic [1:0] exp_t [7];
        exp_t = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
        do_vend(2'b00, 5'd31, 0, 1'b0);
        checks++; if (n !== 7) begin failures++; $display("FAIL max_coin_count got=%0d exp=7", n); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (ctype[i] !== exp_t[i]) begin failures++; $display("FAIL max_coin_type[%0d] got=%b exp=%b", i, ctype[i], exp_t[i]); end
        end
        checks++; if (ccyc[0] - last_mot !== 3) begin failures++; $display("FAIL max_sense_latch got=%0d exp=3", ccyc[0] - last_mot); end
        checks++; if (ccyc[6] - ccyc[5] !== 5) begin failures++; $display("FAIL max_coin_gap got=%0d exp=5", ccyc[6] - ccyc[5]); end
        checks++; if (derr !== 2'b00 || mot !== 8) begin failures++; $display("FAIL max_done got=%b/%0d exp=00/8", derr, mot); end
    endtask

    task automatic test_reset_abort();
        clear_mon();
        sel = 2'b10; credit = 5'd7; vend_req = 1'b1;
        tick();
        vend_req = 1'b0;
        for (int i = 0; i < 50 && mot < 4; i++) tick();
        #2 reset = 1'b0;
        #1;
        checks++; if (motor_on !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort_async got=%b%b exp=00", motor_on, busy); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_mon();
        repeat (30) tick();
        checks++; if (dn !== 0 || n !== 0) begin failures++; $display("FAIL abort_quiet got=%0d/%0d exp=0/0", dn, n); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        int first_done;
        bit busy_gap;
        clear_mon();
        first_done = 0;
        busy_gap = 1'b1;
        sel = 2'b11; credit = 5'd0; vend_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (first_done != 0 && cyc == first_done + 1) busy_gap = busy;
            if (done && first_done == 0) first_done = cyc;
        end
        vend_req = 1'b0;
        repeat (6) tick();
        checks++; if (dn !== 3) begin failures++; $display("FAIL b2b_done_count got=%0d exp=3", dn); end
        checks++; if (first_done !== 3 || dcyc !== 11) begin failures++; $display("FAIL b2b_done_cycles got=%0d,%0d exp=3,11", first_done, dcyc); end
        checks++; if (busy_gap !== 1'b0) begin failures++; $display("FAIL b2b_busy_gap got=%b exp=0", busy_gap); end
    endtask

    initial begin
        test_reset();
        test_pen_dime();
        test_insufficient();
        test_invalid_sel();
        test_jam_timeout();
        test_max_change();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
